// File: rtl/addsub_if.sv
// addsub_if: valid/ready operand and result channels of the pipelined add/subtract unit
interface addsub_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
  );
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/subtract, one CW-bit carry chunk per stage, C/V/Z/N flags
// Optional signed saturation of the result when ADDSUB_SAT_EN is defined.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic     clk,
  input logic     rst,
  addsub_if.slave io
);
  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  logic [STAGES-1:0] vld, rc, sc, sv, nc;
  logic [STAGES:0]   en;
  logic [WIDTH-1:0]  ra [STAGES];
  logic [WIDTH-1:0]  rb [STAGES];
  logic [WIDTH-1:0]  rs [STAGES];
  logic [WIDTH-1:0]  sa [STAGES];
  logic [WIDTH-1:0]  sb [STAGES];
  logic [WIDTH-1:0]  ss [STAGES];
  logic [WIDTH-1:0]  ns [STAGES];
  logic [CW:0]       part;
  logic [WIDTH-1:0]  sum, res;
  logic              ovf;
  // en[k]: stage k can load this cycle (empty, or draining); ripples back from out_ready
  always_comb begin
    en[STAGES] = io.out_ready;
    for (int k = L; k >= 0; k--) en[k] = !vld[k] || en[k+1];
  end
  assign io.in_ready  = !rst && en[0];
  assign io.out_valid = vld[L];
  always_comb begin
    sa[0] = io.a;
    sb[0] = io.b ^ {WIDTH{io.sub}};
    ss[0] = '0;
    sc[0] = io.sub;
    sv[0] = io.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      sa[k] = ra[k-1];
      sb[k] = rb[k-1];
      ss[k] = rs[k-1];
      sc[k] = rc[k-1];
      sv[k] = vld[k-1];
    end
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part  = {1'b0, sa[k][k*CW +: CW]} + {1'b0, sb[k][k*CW +: CW]} + {{CW{1'b0}}, sc[k]};
      ns[k] = ss[k];
      ns[k][k*CW +: CW] = part[CW-1:0];
      nc[k] = part[CW];
    end
  end
  assign sum = ns[L];
  assign ovf = (sa[L][WIDTH-1] == sb[L][WIDTH-1]) && (sum[WIDTH-1] != sa[L][WIDTH-1]);
`ifdef ADDSUB_SAT_EN
  assign res = ovf ? {sa[L][WIDTH-1], {(WIDTH-1){!sa[L][WIDTH-1]}}} : sum;
`else
  assign res = sum;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      vld        <= '0;
      rc         <= '0;
      io.result  <= '0;
      io.flag_c  <= 1'b0;
      io.flag_v  <= 1'b0;
      io.flag_z  <= 1'b0;
      io.flag_n  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          vld[k] <= sv[k];
          if (sv[k]) begin
            ra[k] <= sa[k];
            rb[k] <= sb[k];
            rs[k] <= ns[k];
            rc[k] <= nc[k];
          end
        end
      end
      if (en[L] && sv[L]) begin
        io.result <= res;
        io.flag_c <= nc[L];
        io.flag_v <= ovf;
        io.flag_z <= (res == '0);
        io.flag_n <= res[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: random and directed stimulus checked against a queue-based arithmetic model
module tb_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [35:0] q [$];
  logic        prev_stall = 1'b0;
  logic [35:0] prev_out;
  addsub_if #(.WIDTH(32)) io ();
  addsub_pipe #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // {c, v, z, n, result} from plain signed/unsigned arithmetic
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [33:0] e;
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    e = s ? $signed({{2{x[31]}}, x}) - $signed({{2{y[31]}}, y})
          : $signed({{2{x[31]}}, x}) + $signed({{2{y[31]}}, y});
    w = {1'b0, x} + {1'b0, y};
    c = s ? (x >= y) : w[32];
    v = (e > 34'sd2147483647) || (e < -34'sd2147483648);
    r = e[31:0];
`ifdef ADDSUB_SAT_EN
    if (v) r = (e < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {c, v, r == 32'd0, r[31], r};
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_rst", {63'd0, io.in_ready}, 64'd0);
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {27'd0, io.out_valid, io.flag_c, io.flag_v, io.flag_z, io.flag_n, io.result},
                          {27'd0, 1'b1, prev_out});
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else chk("out", {28'd0, io.flag_c, io.flag_v, io.flag_z, io.flag_n, io.result}, {28'd0, q.pop_front()});
      end
      if (io.in_valid && io.in_ready) q.push_back(model(io.a, io.b, io.sub));
      prev_stall = io.out_valid && !io.out_ready;
      prev_out   = {io.flag_c, io.flag_v, io.flag_z, io.flag_n, io.result};
    end
  end
  task automatic set_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    io.in_valid = 1'b1;
    io.a = x;
    io.b = y;
    io.sub = s;
  endtask
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        output logic [31:0] r, output logic [3:0] f);
    int n;
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    set_op(x, y, s);
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!io.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", 64'(n), 64'd4);
    r = io.result;
    f = {io.flag_c, io.flag_v, io.flag_z, io.flag_n};
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int acc, idx, outs, first, last, n;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.sub = 1'b0; io.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", {27'd0, io.out_valid, io.flag_c, io.flag_v, io.flag_z, io.flag_n, io.result}, 64'd0);
    chk("rst_in_ready", {63'd0, io.in_ready}, 64'd1);
    chk("model_pin", {28'd0, model(32'd3, 32'd5, 1'b1)}, {28'd0, 4'b0001, 32'hFFFF_FFFE});
    run_op(32'd5, 32'd3, 1'b0, r, f);           chk("add_5_3", {f, r}, {4'b0000, 32'd8});
    run_op(32'd3, 32'd5, 1'b1, r, f);           chk("sub_3_5", {f, r}, {4'b0001, 32'hFFFF_FFFE});
    run_op(32'd5, 32'd5, 1'b1, r, f);           chk("sub_5_5", {f, r}, {4'b1010, 32'd0});
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, r, f);   chk("ripple", {f, r}, {4'b1010, 32'd0});
`ifdef ADDSUB_SAT_EN
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, r, f);   chk("pos_ovf", {f, r}, {4'b0100, 32'h7FFF_FFFF});
    run_op(32'h8000_0000, 32'd1, 1'b1, r, f);   chk("neg_ovf", {f, r}, {4'b1101, 32'h8000_0000});
`else
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, r, f);   chk("pos_ovf", {f, r}, {4'b0101, 32'h8000_0000});
    run_op(32'h8000_0000, 32'd1, 1'b1, r, f);   chk("neg_ovf", {f, r}, {4'b1100, 32'h7FFF_FFFF});
`endif
    // backpressure: six back-to-back ops into a stalled pipe
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    acc = 0; idx = 0;
    set_op($urandom, $urandom, 1'($urandom));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (io.in_ready) begin acc++; idx++; end
      @(posedge clk); #1;
      if (idx < 6) set_op($urandom, $urandom, 1'($urandom)); else io.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("full_accepted", 64'(acc), 64'd4);
    chk("full_in_ready", {63'd0, io.in_ready}, 64'd0);
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    outs = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (io.out_valid) begin outs++; if (first < 0) first = c; last = c; end
      if (io.in_valid && io.in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 6) set_op($urandom, $urandom, 1'($urandom)); else io.in_valid = 1'b0;
    end
    chk("drain_count", 64'(outs), 64'd6);
    chk("drain_contig", 64'(last - first + 1), 64'd6);
    chk("drain_empty", 64'(q.size()), 64'd0);
    // reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      set_op($urandom, $urandom, 1'($urandom));
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_result", {28'd0, io.flag_c, io.flag_v, io.flag_z, io.flag_n, io.result}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_no_out", {63'd0, io.out_valid}, 64'd0);
      @(negedge clk);
    end
    run_op(32'd100, 32'd58, 1'b1, r, f);        chk("post_rst", {f, r}, {4'b1000, 32'd42});
    // random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      io.in_valid  = ($urandom_range(0, 3) != 0);
      io.a         = pick();
      io.b         = pick();
      io.sub       = 1'($urandom);
      io.out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("final_empty", 64'(q.size()), 64'd0);
    chk("final_out_valid", {63'd0, io.out_valid}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
